// File: rtl/button_conditioner_pkg.sv
// Shared constants and sizing helpers for the pushbutton front end.
// The default sample divider gives a 1 kHz debounce tick from the 16 MHz board clock.
package button_conditioner_pkg;

  localparam int unsigned BOARD_CLK_HZ       = 16_000_000;
  localparam int unsigned SAMPLE_HZ          = 1_000;
  localparam int unsigned DEFAULT_SAMPLE_DIV = BOARD_CLK_HZ / SAMPLE_HZ;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: two-flop synchronizer, tick-driven debouncer and
// registered press/release edge pulses derived from the stable state.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SAMPLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic tick,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned     DW   = cnt_w(DEBOUNCE_SAMPLES - 1);
  localparam logic [DW-1:0]   LAST = DW'(DEBOUNCE_SAMPLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          stable;
  logic          stable_q;
  logic [DW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a        <= 1'b0;
      sync_b        <= 1'b0;
      stable        <= 1'b0;
      stable_q      <= 1'b0;
      count         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_a        <= pin;
      sync_b        <= sync_a;
      stable_q      <= stable;
      press_pulse   <= stable & ~stable_q;
      release_pulse <= ~stable & stable_q;
      // Any agreeing sample restarts the run, so short bounces never flip the state.
      if (tick) begin
        if (sync_b == stable) begin
          count <= '0;
        end else if (count == LAST) begin
          stable <= ~stable;
          count  <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioning between board pins and the SoC core: debounced levels,
// press/release pulses, sticky IRQs with ack, and a channel-0 long-press reset request.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN            = 4,
  parameter int unsigned SAMPLE_DIV       = DEFAULT_SAMPLE_DIV,
  parameter int unsigned DEBOUNCE_SAMPLES = 8,
  parameter int unsigned HOLD_SAMPLES     = 2000,
  parameter int unsigned ACTIVE_LOW       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] irq_ack,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] irq_req,
  output logic             cpu_reset_req
);

  localparam int unsigned      PW       = cnt_w(SAMPLE_DIV - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(SAMPLE_DIV - 1);
  localparam int unsigned      HW       = cnt_w(HOLD_SAMPLES);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(HOLD_SAMPLES);
  localparam logic [N_BTN-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]    pre_cnt;
  logic             sample_tick;
  logic [N_BTN-1:0] pin_pressed;
  logic [HW-1:0]    hold_cnt;

  assign sample_tick = (pre_cnt == PRE_LAST);
  assign pin_pressed = btn_raw ^ POL_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (sample_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .pin          (pin_pressed[i]),
      .tick         (sample_tick),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

  // A press in the same cycle as an ack wins, so a request is never dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_req <= '0;
    end else begin
      irq_req <= btn_press | (irq_req & ~irq_ack);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt      <= '0;
      cpu_reset_req <= 1'b0;
    end else begin
      cpu_reset_req <= btn_level[0] && (hold_cnt == HOLD_MAX);
      if (!btn_level[0]) begin
        hold_cnt <= '0;
      end else if (sample_tick && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a behavioural model.
module tb_button_conditioner;

  localparam int NB   = 4;
  localparam int SD   = 4;
  localparam int DEB  = 3;
  localparam int HOLD = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] irq_ack = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, irq_req;
  logic          cpu_reset_req;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  button_conditioner #(
    .N_BTN(NB), .SAMPLE_DIV(SD), .DEBOUNCE_SAMPLES(DEB),
    .HOLD_SAMPLES(HOLD), .ACTIVE_LOW(0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .irq_ack      (irq_ack),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .irq_req      (irq_req),
    .cpu_reset_req(cpu_reset_req)
  );

  always #5 clk = ~clk;

  // Reference model: pin history, tick schedule, disagreeing-sample runs.
  int            m_phase;
  logic [NB-1:0] m_pin_prev1, m_pin_prev2;
  logic [NB-1:0] m_stable, m_stable_last, m_press, m_rel, m_irq;
  int            m_run [NB];
  int            m_hold;
  logic          m_req;

  logic [16:0] obs;
  assign obs = {btn_level, btn_press, btn_release, irq_req, cpu_reset_req};

  function automatic logic [16:0] exp_vec();
    return {m_stable, m_press, m_rel, m_irq, m_req};
  endfunction

  task automatic model_edge();
    logic          tick;
    logic [NB-1:0] synced, n_press, n_rel, n_irq;
    logic          n_req;
    if (reset) begin
      m_phase = 0; m_pin_prev1 = '0; m_pin_prev2 = '0;
      m_stable = '0; m_stable_last = '0; m_press = '0; m_rel = '0; m_irq = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_hold = 0; m_req = 1'b0;
    end else begin
      tick    = (m_phase % SD) == SD - 1;
      m_phase = m_phase + 1;
      synced  = m_pin_prev2;
      m_pin_prev2 = m_pin_prev1;
      m_pin_prev1 = btn_raw;
      n_press = m_stable & ~m_stable_last;
      n_rel   = ~m_stable & m_stable_last;
      n_irq   = m_press | (m_irq & ~irq_ack);
      n_req   = m_stable[0] && (m_hold == HOLD);
      if (!m_stable[0]) m_hold = 0;
      else if (tick && m_hold < HOLD) m_hold = m_hold + 1;
      m_stable_last = m_stable;
      if (tick) begin
        for (int i = 0; i < NB; i++) begin
          if (synced[i] != m_stable[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DEB) begin
              m_stable[i] = ~m_stable[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_press = n_press; m_rel = n_rel; m_irq = n_irq; m_req = n_req;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_raw = '0; irq_ack = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_raw = 4'hF; irq_ack = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (obs !== 17'h0) begin bad++; $display("FAIL reset_hold: got %h want 0", obs); end
    end
    reset = 1'b0;
    step();
    total++;
    if (obs !== 17'h0) begin bad++; $display("FAIL reset_release: got %h want 0", obs); end
  endtask

  task automatic test_clean_press();
    int first = -1, npress = 0, other = 0;
    do_reset();
    btn_raw = 4'b0010;
    for (int c = 1; c <= 30; c++) begin
      step();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL press_model: got %h want %h", obs, exp_vec()); end
      if (btn_press[1]) begin npress++; if (first < 0) first = c; end
      if (((btn_press | btn_level | irq_req) & 4'b1101) != 0) other++;
    end
    total++;
    if (npress != 1) begin bad++; $display("FAIL press_count: got %0d want 1", npress); end
    total++;
    if (first < 1 || first > 15) begin bad++; $display("FAIL press_latency: got %0d want 1..15", first); end
    total++;
    if (btn_level[1] !== 1'b1 || irq_req[1] !== 1'b1) begin
      bad++; $display("FAIL press_level_irq: got %b%b want 11", btn_level[1], irq_req[1]);
    end
    total++;
    if (other != 0) begin bad++; $display("FAIL press_other_ch: got %0d want 0", other); end
  endtask

  task automatic test_bounce();
    int seg_val [4] = '{1, 0, 1, 0};
    int seg_len [4] = '{8, 4, 8, 24};
    int seen = 0;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      btn_raw[2] = seg_val[s][0];
      for (int c = 0; c < seg_len[s]; c++) begin
        step();
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL bounce_model: got %h want %h", obs, exp_vec()); end
        if (btn_press[2] || btn_level[2]) seen++;
      end
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL bounce_reject: got %0d cycles active want 0", seen); end
  endtask

  task automatic test_handshake();
    int c;
    do_reset();
    btn_raw = 4'b0010;
    for (c = 0; c < 30 && !irq_req[1]; c++) step();
    total++;
    if (!irq_req[1]) begin bad++; $display("FAIL hs_irq_set: got 0 want 1 within 30 clk"); end
    irq_ack = 4'b0010;
    step();
    irq_ack = '0;
    total++;
    if (irq_req[1] !== 1'b0) begin bad++; $display("FAIL hs_ack_clear: got %b want 0", irq_req[1]); end
    btn_raw = '0;
    for (c = 0; c < 30 && btn_level[1]; c++) step();
    step(); step();
    irq_ack = 4'b0010;
    btn_raw = 4'b0010;
    for (c = 0; c < 30 && !btn_press[1]; c++) begin
      step();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL hs_model: got %h want %h", obs, exp_vec()); end
    end
    total++;
    if (!btn_press[1]) begin bad++; $display("FAIL hs_repress: got 0 want press within 30 clk"); end
    step();
    total++;
    if (irq_req[1] !== 1'b1) begin bad++; $display("FAIL hs_set_wins: got %b want 1", irq_req[1]); end
    step();
    total++;
    if (irq_req[1] !== 1'b0) begin bad++; $display("FAIL hs_held_ack: got %b want 0", irq_req[1]); end
    irq_ack = '0;
  endtask

  task automatic test_long_press();
    int c, cl, seen_req = 0, seen_lvl = 0;
    do_reset();
    btn_raw = 4'b0001;
    for (c = 0; c < 30 && !btn_level[0]; c++) step();
    cl = cyc;
    for (c = 0; c < 40 && !cpu_reset_req; c++) step();
    total++;
    if (!cpu_reset_req || (cyc - cl) != 21) begin
      bad++; $display("FAIL long_rise: got req=%b after %0d clk want 1 after 21", cpu_reset_req, cyc - cl);
    end
    for (c = 0; c < 10; c++) step();
    total++;
    if (cpu_reset_req !== 1'b1) begin bad++; $display("FAIL long_stay: got %b want 1", cpu_reset_req); end
    btn_raw = '0;
    for (c = 0; c < 30 && btn_level[0]; c++) step();
    total++;
    if (btn_level[0] !== 1'b0 || cpu_reset_req !== 1'b1) begin
      bad++; $display("FAIL long_until_release: got lvl=%b req=%b want 0 1", btn_level[0], cpu_reset_req);
    end
    step();
    total++;
    if (cpu_reset_req !== 1'b0) begin bad++; $display("FAIL long_fall: got %b want 0", cpu_reset_req); end

    do_reset();
    btn_raw = 4'b0001;
    for (c = 0; c < 60; c++) begin
      if (c == 16) btn_raw = '0;
      step();
      if (cpu_reset_req) seen_req++;
      if (btn_level[0]) seen_lvl++;
    end
    total++;
    if (seen_req != 0 || seen_lvl == 0) begin
      bad++; $display("FAIL long_short_hold: got req=%0d lvl=%0d cycles want 0 and >0", seen_req, seen_lvl);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    btn_raw = 4'b1001;
    for (c = 0; c < 30 && btn_press == 0; c++) step();
    total++;
    if (btn_press !== 4'b1001) begin bad++; $display("FAIL multi_press: got %b want 1001", btn_press); end
    step();
    total++;
    if (irq_req !== 4'b1001) begin bad++; $display("FAIL multi_irq: got %b want 1001", irq_req); end
  endtask

  task automatic test_random();
    int hold_left [NB];
    do_reset();
    for (int i = 0; i < NB; i++) hold_left[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          btn_raw[i]   = $urandom_range(0, 1) != 0;
          hold_left[i] = $urandom_range(1, 24);
        end else begin
          hold_left[i]--;
        end
        irq_ack[i] = ($urandom_range(0, 3) == 0);
      end
      reset = ($urandom_range(0, 399) == 0);
      step();
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL random_model cyc %0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    reset = 1'b0;
    irq_ack = '0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_handshake();
    test_long_press();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end conditioning stage between the raw board pushbutton pins and the RISC-V SoC core.
- Per channel:
  - two-flop synchronizer
  - sample-tick debouncer
  - clean level, single-cycle press/release pulses
  - sticky interrupt request with acknowledge handshake
- Channel 0 also produces a long-press CPU reset request; the top level inverts it into the core's active-low reset.

Parameters:
- N_BTN, 4, number of button channels (1..8).
- SAMPLE_DIV, 16000, clk cycles per debounce sample tick (1 kHz at 16 MHz).
- DEBOUNCE_SAMPLES, 8, consecutive disagreeing samples needed to flip the stable state (>=2).
- HOLD_SAMPLES, 2000, stable-pressed ticks on channel 0 before cpu_reset_req asserts.
- ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- btn_raw, input, N_BTN, asynchronous raw button pins.
- irq_ack, input, N_BTN, per-channel interrupt acknowledge (level, sampled each clk).
- btn_level, output, N_BTN, debounced pressed state (1 = pressed).
- btn_press, output, N_BTN, 1-cycle pulse on debounced press.
- btn_release, output, N_BTN, 1-cycle pulse on debounced release.
- irq_req, output, N_BTN, sticky request, set by press, cleared by ack.
- cpu_reset_req, output, 1, long-press request from channel 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - all outputs 0.
  - synchronizer flops and stable state = released.
  - all counters 0.
- Reset mid-operation discards every pending debounce, pulse, irq and hold count.
- Polarity: pressed = btn_raw XOR ACTIVE_LOW, applied before the synchronizer.
- Synchronizer:
  - 2 flops per channel; the synced value lags the pin by 2 clk.
  - No logic between the two flops.
- Prescaler:
  - counter runs 0..SAMPLE_DIV-1.
  - tick is high for one clk when the counter equals SAMPLE_DIV-1; the counter then wraps to 0.
  - Free-running, shared by all channels.
- Debounce, per channel, evaluated only on tick:
  - synced == stable: count <= 0.
  - synced != stable and count < DEBOUNCE_SAMPLES-1: count <= count+1.
  - synced != stable and count == DEBOUNCE_SAMPLES-1: stable toggles, count <= 0.
  - A single agreeing sample restarts the count, so bounces shorter than DEBOUNCE_SAMPLES ticks are rejected.
- Pulses:
  - btn_press/btn_release are registered and high exactly on the clk after stable changes, for one cycle.
  - btn_level equals stable.
  - At most one transition per channel per tick.
- IRQ handshake, per channel:
  - press pulse: irq_req <= 1.
  - irq_ack high and no press pulse: irq_req <= 0.
  - press and ack in the same cycle: set wins; the request is never lost.
  - release never affects irq_req.
  - ack while irq_req=0: no effect.
- Long press, channel 0 only:
  - hold_cnt increments on tick while stable[0]=1, saturating at HOLD_SAMPLES.
  - hold_cnt clears to 0 on the clk after stable[0] goes 0.
  - cpu_reset_req = registered (hold_cnt == HOLD_SAMPLES); it stays high until release is debounced.
- Widths: use $clog2 sizing for prescaler, debounce and hold counters. No counter wraps except the prescaler.

Decomposition:
- Shared package holds:
  - sample-tick and counter-width helper constants (CNT_W functions).
  - default SAMPLE_DIV for the 16 MHz board clock.
- Sub-module debounce_channel:
  - inputs: clk, reset, pin, tick.
  - outputs: level, press, release.
  - instantiated N_BTN times via generate.
- Prescaler, IRQ latches and hold counter stay in button_conditioner.

Test Plan:
All scenarios use SAMPLE_DIV=4, DEBOUNCE_SAMPLES=3, HOLD_SAMPLES=5, N_BTN=4, ACTIVE_LOW=0.
1. Reset: hold reset 3 clk with btn_raw=4'hF -> all outputs 0 during reset and on the first clk after deassertion.
2. Clean press: btn_raw[1] 0->1 and held -> btn_press[1] pulses once, within 2 sync + 3 ticks (<=15 clk); btn_level[1]=1; irq_req[1]=1 stays high; no other channel changes.
3. Bounce rejection: btn_raw[2] high for 2 ticks, low 1 tick, high 2 ticks, then low -> no btn_press[2], btn_level[2] stays 0.
4. Handshake: after a press, irq_ack[1]=1 for 1 clk -> irq_req[1]=0 next clk. Re-press with irq_ack held high in the press cycle -> irq_req[1]=1.
5. Long press: hold btn_raw[0]=1 -> cpu_reset_req rises 5 ticks after btn_level[0]. Release -> cpu_reset_req falls on the clk after btn_level[0] drops. A 4-tick hold never asserts it.
6. Multi-channel: press channels 0 and 3 in the same clk -> btn_press=4'b1001 in the same cycle; irq_req=4'b1001.
